// File: rtl/encode_uart_tx.sv
// 8N1 UART transmitter for the encoder byte stream.
// Enable and baud divisor are written over the shared host register bus.
module encode_uart_tx #(
  parameter logic [7:0]  ADDR_EN      = 8'h01,
  parameter logic [7:0]  ADDR_BAUD    = 8'h02,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434,
  parameter logic [15:0] BAUD_DIV_MIN = 16'd4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        m_wr,
  input  logic [7:0]  m_addr,
  input  logic [15:0] m_wrdata,
  input  logic [7:0]  data_in,
  output logic        Rs232_Tx,
  output logic        Tx_Busy,
  output logic        Tx_Done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [15:0] baud_div_q, baud_div_d;
  logic [15:0] active_div_q, active_div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        last_tick;

  assign last_tick = (baud_cnt_q == active_div_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    baud_div_d   = baud_div_q;
    active_div_d = active_div_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    if (m_wr && m_addr == ADDR_EN)   en_d = m_wrdata[0];
    if (m_wr && m_addr == ADDR_BAUD)
      baud_div_d = (m_wrdata < BAUD_DIV_MIN) ? BAUD_DIV_MIN : m_wrdata;

    // Outputs are computed one edge early so the line comes straight off a flop.
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (en_q) begin
          state_d      = START;
          shreg_d      = data_in;
          active_div_d = baud_div_q;
          baud_cnt_d   = 16'd0;
          tx_d         = 1'b0;
          busy_d       = 1'b1;
        end
      end
      START: begin
        baud_cnt_d = baud_cnt_q + 16'd1;
        if (last_tick) begin
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          state_d    = DATA;
          tx_d       = shreg_q[0];
        end
      end
      DATA: begin
        baud_cnt_d = baud_cnt_q + 16'd1;
        if (last_tick) begin
          baud_cnt_d = 16'd0;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[bit_cnt_q + 3'd1];
          end
        end
      end
      STOP: begin
        baud_cnt_d = baud_cnt_q + 16'd1;
        if (last_tick) begin
          baud_cnt_d = 16'd0;
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      baud_div_q   <= BAUD_DIV_RST;
      active_div_q <= BAUD_DIV_RST;
      baud_cnt_q   <= 16'd0;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'd0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      baud_div_q   <= baud_div_d;
      active_div_q <= active_div_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign Rs232_Tx = tx_q;
  assign Tx_Busy  = busy_q;
  assign Tx_Done  = done_q;

endmodule

// File: tb/tb_encode_uart_tx.sv
// Randomized bench for encode_uart_tx; expected line levels come from a frame-slot model.
module tb_encode_uart_tx;
  localparam logic [7:0] A_EN   = 8'h01;
  localparam logic [7:0] A_BAUD = 8'h02;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        m_wr = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_wrdata = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic        Rs232_Tx, Tx_Busy, Tx_Done;

  int vectors = 0;
  int errors  = 0;
  logic obs_tx[$], obs_busy[$], obs_done[$];

  always #5 Clk = ~Clk;

  encode_uart_tx dut (
    .Clk(Clk), .Rst_n(Rst_n), .m_wr(m_wr), .m_addr(m_addr), .m_wrdata(m_wrdata),
    .data_in(data_in), .Rs232_Tx(Rs232_Tx), .Tx_Busy(Tx_Busy), .Tx_Done(Tx_Done)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Line level k cycles after frame start: slot 0 start, slots 1..8 data LSB first, then high.
  function automatic logic exp_tx(input logic [7:0] b, input int n, input int k);
    int slot;
    slot = k / n;
    if (k >= 10 * n) return 1'b1;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge Clk);
    m_wr = 1'b1; m_addr = a; m_wrdata = d;
    @(negedge Clk);
    m_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0; m_wr = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic wait_busy(output int c);
    c = 0;
    do begin
      @(negedge Clk);
      c++;
    end while (!Tx_Busy && c < 20);
  endtask

  // Records the line from the current negedge; optionally injects one write/data change.
  task automatic capture(input int cycles, input int act, input logic act_wr,
                         input logic [7:0] a, input logic [15:0] d,
                         input logic act_din, input logic [7:0] din);
    obs_tx.delete(); obs_busy.delete(); obs_done.delete();
    for (int k = 0; k < cycles; k++) begin
      if (k > 0) @(negedge Clk);
      obs_tx.push_back(Rs232_Tx);
      obs_busy.push_back(Tx_Busy);
      obs_done.push_back(Tx_Done);
      if (k == act) begin
        if (act_wr) begin m_wr = 1'b1; m_addr = a; m_wrdata = d; end
        if (act_din) data_in = din;
      end else if (k == act + 1) begin
        m_wr = 1'b0;
      end
    end
    m_wr = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    logic [7:0] b;
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    vectors++; if (Rs232_Tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", Rs232_Tx); end
    vectors++; if (Tx_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Tx_Busy); end
    vectors++; if (Tx_Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Tx_Done); end
    Rst_n = 1'b1;
    b = 8'($urandom);
    data_in = b;
    wr(A_EN, 16'h0001);
    wait_busy(c);
    vectors++; if (c != 1 || Tx_Busy !== 1'b1) begin errors++; $display("FAIL reset_start_latency: got %0d busy=%b want 1", c, Tx_Busy); end
    capture(4345, 50, 1'b1, A_EN, 16'h0000, 1'b0, 8'h00);
    for (int k = 0; k < 4345; k++) begin
      vectors++;
      if (obs_tx[k] !== exp_tx(b, 434, k) || obs_busy[k] !== (k < 4340) || obs_done[k] !== (k == 4340)) begin
        errors++;
        $display("FAIL reset_default_div k=%0d: got tx/busy/done %b%b%b want %b%b%b", k,
                 obs_tx[k], obs_busy[k], obs_done[k], exp_tx(b, 434, k), k < 4340, k == 4340);
      end
    end
  endtask

  task automatic test_basic();
    int c, nbusy, ndone, kk;
    logic [9:0] seq;
    seq = 10'b1101001010;
    do_reset();
    wr(A_BAUD, 16'd4);
    data_in = 8'hA5;
    wr(A_EN, 16'h0001);
    wait_busy(c);
    vectors++; if (c != 1 || Tx_Busy !== 1'b1) begin errors++; $display("FAIL basic_start_latency: got %0d busy=%b want 1", c, Tx_Busy); end
    capture(90, 45, 1'b1, A_EN, 16'h0000, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (obs_tx[i*4+2] !== seq[i]) begin errors++; $display("FAIL basic_seq bit%0d: got %b want %b", i, obs_tx[i*4+2], seq[i]); end
    end
    nbusy = 0; ndone = 0;
    for (int k = 0; k < 41; k++) begin nbusy += int'(obs_busy[k]); ndone += int'(obs_done[k]); end
    vectors++; if (nbusy != 40) begin errors++; $display("FAIL basic_busy_len: got %0d want 40", nbusy); end
    vectors++; if (ndone != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", ndone); end
    for (int k = 0; k < 90; k++) begin
      kk = (k < 41) ? k : k - 41;
      vectors++;
      if (obs_tx[k] !== exp_tx(8'hA5, 4, kk) || obs_busy[k] !== (kk < 40) || obs_done[k] !== (kk == 40)) begin
        errors++;
        $display("FAIL basic_b2b k=%0d: got tx/busy/done %b%b%b want %b%b%b", k,
                 obs_tx[k], obs_busy[k], obs_done[k], exp_tx(8'hA5, 4, kk), kk < 40, kk == 40);
      end
    end
  endtask

  task automatic test_div_change();
    int c, n, kk;
    logic [7:0] b, d2;
    do_reset();
    wr(A_BAUD, 16'd4);
    data_in = 8'h3C;
    wr(A_EN, 16'h0001);
    wait_busy(c);
    vectors++; if (c != 1) begin errors++; $display("FAIL div_start_latency: got %0d want 1", c); end
    d2 = 8'($urandom);
    capture(122, 5, 1'b1, A_BAUD, 16'd8, 1'b1, d2);
    for (int k = 0; k < 122; k++) begin
      if (k < 41) begin n = 4; kk = k; b = 8'h3C; end
      else begin n = 8; kk = k - 41; b = d2; end
      vectors++;
      if (obs_tx[k] !== exp_tx(b, n, kk) || obs_busy[k] !== (kk < 10*n) || obs_done[k] !== (kk == 10*n)) begin
        errors++;
        $display("FAIL div_change k=%0d: got tx/busy/done %b%b%b want %b%b%b", k,
                 obs_tx[k], obs_busy[k], obs_done[k], exp_tx(b, n, kk), kk < 10*n, kk == 10*n);
      end
    end
  endtask

  task automatic test_disable_midframe();
    int c;
    do_reset();
    wr(A_BAUD, 16'd4);
    data_in = 8'hFF;
    wr(A_EN, 16'h0001);
    wait_busy(c);
    vectors++; if (c != 1) begin errors++; $display("FAIL dis_start_latency: got %0d want 1", c); end
    capture(80, 16, 1'b1, A_EN, 16'h0000, 1'b1, 8'h00);
    for (int k = 0; k < 80; k++) begin
      vectors++;
      if (obs_tx[k] !== exp_tx(8'hFF, 4, k) || obs_busy[k] !== (k < 40) || obs_done[k] !== (k == 40)) begin
        errors++;
        $display("FAIL disable_mid k=%0d: got tx/busy/done %b%b%b want %b%b%b", k,
                 obs_tx[k], obs_busy[k], obs_done[k], exp_tx(8'hFF, 4, k), k < 40, k == 40);
      end
    end
  endtask

  task automatic test_clamp_ignore();
    int c;
    logic [7:0] b;
    do_reset();
    wr(A_BAUD, 16'($urandom_range(0, 3)));
    wr(8'h07, 16'hFFFF);
    capture(30, -1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    for (int k = 0; k < 30; k++) begin
      vectors++;
      if (obs_busy[k] !== 1'b0 || obs_tx[k] !== 1'b1) begin
        errors++; $display("FAIL ignored_addr_en k=%0d: got busy=%b tx=%b want 0 1", k, obs_busy[k], obs_tx[k]);
      end
    end
    b = 8'($urandom);
    data_in = b;
    wr(A_EN, 16'h0001);
    wait_busy(c);
    vectors++; if (c != 1) begin errors++; $display("FAIL clamp_start_latency: got %0d want 1", c); end
    capture(41, -1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    for (int k = 0; k < 41; k++) begin
      vectors++;
      if (obs_tx[k] !== exp_tx(b, 4, k) || obs_busy[k] !== (k < 40) || obs_done[k] !== (k == 40)) begin
        errors++;
        $display("FAIL clamp k=%0d: got tx/busy/done %b%b%b want %b%b%b", k,
                 obs_tx[k], obs_busy[k], obs_done[k], exp_tx(b, 4, k), k < 40, k == 40);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int c, n, ndone;
    logic [7:0] b;
    do_reset();
    n = $urandom_range(4, 6);
    wr(A_BAUD, 16'(n));
    data_in = 8'($urandom);
    wr(A_EN, 16'h0001);
    wait_busy(c);
    repeat (2*n + 1) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    vectors++; if (Tx_Busy !== 1'b0 || Rs232_Tx !== 1'b1 || Tx_Done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: got busy=%b tx=%b done=%b want 0 1 0", Tx_Busy, Rs232_Tx, Tx_Done);
    end
    ndone = 0;
    repeat (3) begin @(negedge Clk); ndone += int'(Tx_Done); end
    Rst_n = 1'b1;
    capture(40, -1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    for (int k = 0; k < 40; k++) ndone += int'(obs_done[k]) + int'(obs_busy[k]);
    vectors++; if (ndone != 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d done/busy cycles want 0", ndone); end
    b = 8'($urandom);
    data_in = b;
    wr(A_EN, 16'h0001);
    wait_busy(c);
    vectors++; if (c != 1) begin errors++; $display("FAIL reset_mid_restart: got %0d want 1", c); end
    capture(436, -1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    for (int k = 0; k < 436; k++) begin
      vectors++;
      if (obs_tx[k] !== exp_tx(b, 434, k) || obs_busy[k] !== 1'b1) begin
        errors++; $display("FAIL reset_mid_div k=%0d: got tx=%b busy=%b want %b 1", k, obs_tx[k], obs_busy[k], exp_tx(b, 434, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int c, n, p, act, kk;
    logic [7:0] b1, b2, b;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n = $urandom_range(4, 12);
      p = 10*n + 1;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      wr(A_BAUD, 16'(n));
      data_in = b1;
      wr(A_EN, 16'h0001);
      wait_busy(c);
      vectors++; if (c != 1) begin errors++; $display("FAIL b2b_start_latency it=%0d: got %0d want 1", it, c); end
      act = $urandom_range(1, 10*n);
      capture(2*p, act, 1'b0, 8'h00, 16'h0000, 1'b1, b2);
      for (int k = 0; k < 2*p; k++) begin
        kk = (k < p) ? k : k - p;
        b  = (k < p) ? b1 : b2;
        vectors++;
        if (obs_tx[k] !== exp_tx(b, n, kk) || obs_busy[k] !== (kk < 10*n) || obs_done[k] !== (kk == 10*n)) begin
          errors++;
          $display("FAIL b2b it=%0d n=%0d k=%0d: got tx/busy/done %b%b%b want %b%b%b", it, n, k,
                   obs_tx[k], obs_busy[k], obs_done[k], exp_tx(b, n, kk), kk < 10*n, kk == 10*n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_change();
    test_disable_midframe();
    test_clamp_ignore();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/encode_uart_tx.md
Name: encode_uart_tx

Overview:
Serial transmitter that directly consumes the 8-bit encoder byte produced by the encoder control stage. It sends that byte to the host as 8N1 UART frames. Transmit enable and baud divisor are host-writable registers on the shared m_wr/m_addr/m_wrdata register bus. It sits between the encoder control stage and the RS-232 pin.

Parameters:
ADDR_EN, 8'h01, register address of transmit enable (bit 0 of m_wrdata)
ADDR_BAUD, 8'h02, register address of baud divisor (clocks per bit, m_wrdata[15:0])
BAUD_DIV_RST, 16'd434, reset baud divisor (115200 baud at 50 MHz)
BAUD_DIV_MIN, 16'd4, minimum legal divisor; smaller writes are clamped to this value

Ports:
Clk  input  1  system clock
Rst_n  input  1  asynchronous active-low reset
m_wr  input  1  host register write strobe, one cycle
m_addr  input  8  host register address
m_wrdata  input  16  host register write data
data_in  input  8  encoder byte from the encoder control stage (registered, stable per Clk)
Rs232_Tx  output  1  serial line, idle high
Tx_Busy  output  1  high while a frame is in progress
Tx_Done  output  1  one-cycle pulse at end of each frame

Behaviour:
- Clock and reset: single clock Clk; Rst_n is asynchronous, active-low. All state is reset asynchronously.
- Reset values:
  - en = 0, baud_div = BAUD_DIV_RST, state = IDLE.
  - Rs232_Tx = 1, Tx_Busy = 0, Tx_Done = 0.
  - bit counter = 0, baud counter = 0, shift register = 0.
- Register writes:
  - m_wr && m_addr == ADDR_EN -> en <= m_wrdata[0].
  - m_wr && m_addr == ADDR_BAUD -> baud_div <= max(m_wrdata, BAUD_DIV_MIN).
  - Writes to any other address are ignored. Registers hold their value otherwise.
  - A write takes effect on the next clock edge.
- Divisor latching: baud_div is copied into active_div at frame start. A divisor write during a frame affects only the next frame.
- State machine, states IDLE, START, DATA, STOP:
  - IDLE: Rs232_Tx = 1, Tx_Busy = 0. If en = 1 at the edge: capture data_in into the shift register, latch active_div, clear the baud counter, go to START. Rs232_Tx goes 0 and Tx_Busy goes 1 on that same edge (registered outputs).
  - START: Rs232_Tx = 0 for active_div cycles, then go to DATA with bit index 0.
  - DATA: Rs232_Tx = shreg[bit index], LSB first. Each bit lasts active_div cycles. After bit 7, go to STOP.
  - STOP: Rs232_Tx = 1 for active_div cycles. On the last cycle, go to IDLE; Tx_Busy drops and Tx_Done = 1 for exactly that one IDLE cycle.
- Baud counter: counts 0 .. active_div-1. The bit advances when the counter reaches active_div-1; the counter then wraps to 0.
- Timing:
  - Frame occupies 10*N cycles with Tx_Busy = 1, where N = active_div.
  - Back-to-back frame period with en held high is 10*N + 1 cycles (one IDLE cycle, coincident with Tx_Done).
- Data sampling: data_in is sampled only at frame start. Changes during a frame do not affect that frame.
- en cleared mid-frame: the current frame completes normally, including Tx_Done. No new frame starts.
- en written 1 during the Tx_Done cycle: a new frame starts at the next edge.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronously). No Tx_Done is produced. en and baud_div revert to their reset values.
- Rs232_Tx is driven from a flop (glitch-free).

Test Plan:
- Reset check: hold Rst_n = 0 -> Rs232_Tx = 1, Tx_Busy = 0, Tx_Done = 0. Read back baud_div = 434 via frame timing after enable.
- Basic frame: write ADDR_BAUD = 4, ADDR_EN = 1, data_in = 8'hA5.
  - Rs232_Tx sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - Tx_Busy high for 40 cycles. Tx_Done pulses once. Next frame starts 41 cycles after the first.
- Mid-frame divisor change: during an 8'h3C frame at N = 4, write ADDR_BAUD = 8 -> current frame stays 40 cycles; next frame is 80 cycles.
- Mid-frame disable and data change: at bit 3 of an 8'hFF frame, write ADDR_EN = 0 and change data_in to 8'h00 -> frame completes as 8'hFF with Tx_Done; line then stays high with no new frame.
- Clamp and ignored address:
  - Write ADDR_BAUD = 1 -> bits last 4 cycles.
  - Write address 8'h07 with data 16'hFFFF -> en and baud_div unchanged.
- Reset mid-frame: assert Rst_n low during DATA -> Rs232_Tx = 1 and Tx_Busy = 0 immediately, no Tx_Done. After release, no frame until en is rewritten.
